// File: rtl/fc_layer_engine.sv
// Fully-connected layer engine: streams activations and row-major weights from
// synchronous SRAMs, accumulates one neuron at a time, then rescales, saturates and writes.
module fc_layer_engine #(
  parameter int DATA_W = 16,
  parameter int FRAC_W = 8,
  parameter int ACC_W  = 40,
  parameter int N_IN   = 784,
  parameter int N_OUT  = 10,
  parameter int RELU   = 1,
  parameter int IN_AW  = 10,
  parameter int W_AW   = 14,
  parameter int OUT_AW = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     start,
  output logic                     busy,
  output logic                     done,
  output logic [IN_AW-1:0]         in_addr,
  input  logic signed [DATA_W-1:0] in_data,
  output logic [W_AW-1:0]          w_addr,
  input  logic signed [DATA_W-1:0] w_data,
  output logic                     out_we,
  output logic [OUT_AW-1:0]        out_addr,
  output logic [DATA_W-1:0]        out_data
);

  localparam int PROD_W = 2 * DATA_W;
  localparam logic [IN_AW-1:0]  I_LAST = IN_AW'(N_IN - 1);
  localparam logic [OUT_AW-1:0] O_LAST = OUT_AW'(N_OUT - 1);
  localparam logic [W_AW-1:0]   W_STEP = W_AW'(N_IN);
  localparam logic signed [ACC_W-1:0] SAT_MAX =
    {{(ACC_W-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] SAT_MIN =
    {{(ACC_W-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};

  typedef enum logic [2:0] {S_IDLE, S_RUN, S_DRAIN, S_WRITE, S_DONE} state_t;

  state_t                   state_q, state_d;
  logic [IN_AW-1:0]         i_q, i_d;
  logic [OUT_AW-1:0]        o_q, o_d;
  logic [W_AW-1:0]          w_base_q, w_base_d;
  logic signed [ACC_W-1:0]  acc_q, acc_d;
  logic                     valid_q, valid_d;

  logic signed [PROD_W-1:0] prod;
  logic signed [ACC_W-1:0]  prod_ext;
  logic signed [ACC_W-1:0]  scaled;
  logic signed [DATA_W-1:0] sat_val;
  logic [DATA_W-1:0]        result;

  assign prod     = in_data * w_data;
  assign prod_ext = {{(ACC_W-PROD_W){prod[PROD_W-1]}}, prod};
  // Arithmetic shift floors toward -inf, so small negative sums become -1, not 0.
  assign scaled   = acc_q >>> FRAC_W;

  always_comb begin
    if (scaled > SAT_MAX)      sat_val = SAT_MAX[DATA_W-1:0];
    else if (scaled < SAT_MIN) sat_val = SAT_MIN[DATA_W-1:0];
    else                       sat_val = scaled[DATA_W-1:0];
    result = sat_val;
    if (RELU != 0 && sat_val[DATA_W-1]) result = '0;
  end

  always_comb begin
    // NOTE: every output and next-state is defaulted first so no path can infer a latch.
    state_d  = state_q;
    i_d      = i_q;
    o_d      = o_q;
    w_base_d = w_base_q;
    acc_d    = acc_q;
    valid_d  = (state_q == S_RUN);
    busy     = 1'b0;
    done     = 1'b0;
    in_addr  = '0;
    w_addr   = '0;
    out_we   = 1'b0;
    out_addr = '0;
    out_data = '0;

    // Read data lags the address by one cycle, hence the delayed valid flag.
    if (valid_q) acc_d = acc_q + prod_ext;

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d  = S_RUN;
          i_d      = '0;
          o_d      = '0;
          w_base_d = '0;
          acc_d    = '0;
        end
      end
      S_RUN: begin
        busy    = 1'b1;
        in_addr = i_q;
        w_addr  = w_base_q + W_AW'(i_q);
        if (i_q == I_LAST) state_d = S_DRAIN;
        else               i_d     = i_q + 1'b1;
      end
      S_DRAIN: begin
        busy    = 1'b1;
        in_addr = i_q;
        w_addr  = w_base_q + W_AW'(i_q);
        state_d = S_WRITE;
      end
      S_WRITE: begin
        busy     = 1'b1;
        in_addr  = i_q;
        w_addr   = w_base_q + W_AW'(i_q);
        out_we   = 1'b1;
        out_addr = o_q;
        out_data = result;
        if (o_q == O_LAST) begin
          state_d = S_DONE;
        end else begin
          state_d  = S_RUN;
          o_d      = o_q + 1'b1;
          i_d      = '0;
          w_base_d = w_base_q + W_STEP;
          acc_d    = '0;
        end
      end
      S_DONE: begin
        done    = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so all flops update together.
    if (reset) begin
      state_q  <= S_IDLE;
      i_q      <= '0;
      o_q      <= '0;
      w_base_q <= '0;
      acc_q    <= '0;
      valid_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      i_q      <= i_d;
      o_q      <= o_d;
      w_base_q <= w_base_d;
      acc_q    <= acc_d;
      valid_q  <= valid_d;
    end
  end

endmodule
